// File: rtl/pwm_cmd_ramp.sv
// pwm_cmd_ramp: throttle command intake, clamp, slew limiting and
// arm/run/failsafe sequencing in front of the motor PWM generator.
module pwm_cmd_ramp #(
  parameter int TICK_CYCLES   = 50000,
  parameter int STEP          = 500,
  parameter int MIN_WIDTH     = 50000,
  parameter int MAX_WIDTH     = 100000,
  parameter int PERIOD        = 1000000,
  parameter int ARM_TICKS     = 2000,
  parameter int TIMEOUT_TICKS = 250
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        arm,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_width,
  output logic [23:0] time_work,
  output logic [23:0] period,
  output logic [1:0]  state,
  output logic        failsafe,
  output logic        at_target
);

  localparam logic [1:0] S_DISARMED = 2'd0;
  localparam logic [1:0] S_ARMING   = 2'd1;
  localparam logic [1:0] S_RUN      = 2'd2;
  localparam logic [1:0] S_FAILSAFE = 2'd3;

  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int AW = $clog2(ARM_TICKS + 1);
  localparam int OW = $clog2(TIMEOUT_TICKS + 1);

  localparam logic [23:0] MIN_W    = 24'(MIN_WIDTH);
  localparam logic [23:0] MAX_W    = 24'(MAX_WIDTH);
  localparam logic [23:0] STEP_W   = 24'(STEP);
  localparam logic [23:0] PERIOD_W = 24'(PERIOD);

  logic [TW-1:0] tick_cnt;
  logic [AW-1:0] arm_cnt, arm_cnt_n;
  logic [OW-1:0] to_cnt, to_cnt_n;
  logic [23:0]   target, target_n;
  logic [23:0]   tw_n, clamped, ramp;
  logic [1:0]    state_n;
  logic          fs_n, tick, accept;

  assign tick   = tick_cnt == TW'(TICK_CYCLES - 1);
  assign accept = cmd_valid & cmd_ready;

  always_comb begin
    clamped = cmd_width;
    if (cmd_width < MIN_W)
      clamped = MIN_W;
    else if (cmd_width > MAX_W)
      clamped = MAX_W;
  end

  // Target is pre-clamped, so stopping at target never over/underflows.
  always_comb begin
    ramp = time_work;
    if (time_work < target)
      ramp = (target - time_work > STEP_W)
           ? time_work + STEP_W : target;
    else if (time_work > target)
      ramp = (time_work - target > STEP_W)
           ? time_work - STEP_W : target;
  end

  always_comb begin
    state_n   = state;
    tw_n      = time_work;
    target_n  = target;
    fs_n      = failsafe;
    arm_cnt_n = arm_cnt;
    to_cnt_n  = to_cnt;
    if (!arm) begin
      state_n  = S_DISARMED;
      tw_n     = '0;
      target_n = MIN_W;
      fs_n     = 1'b0;
    end else begin
      unique case (state)
        S_DISARMED: begin
          state_n   = S_ARMING;
          arm_cnt_n = '0;
          tw_n      = MIN_W;
          target_n  = MIN_W;
        end
        S_ARMING: begin
          tw_n = MIN_W;
          if (tick) begin
            if (arm_cnt == AW'(ARM_TICKS - 1)) begin
              state_n  = S_RUN;
              to_cnt_n = '0;
            end else begin
              arm_cnt_n = arm_cnt + 1'b1;
            end
          end
        end
        S_RUN, S_FAILSAFE: begin
          if (tick)
            tw_n = ramp;
          // A command on the timeout tick wins and restarts the count.
          if (accept) begin
            state_n  = S_RUN;
            target_n = clamped;
            fs_n     = 1'b0;
            to_cnt_n = '0;
          end else if (tick && state == S_RUN) begin
            if (to_cnt == OW'(TIMEOUT_TICKS - 1)) begin
              state_n  = S_FAILSAFE;
              target_n = MIN_W;
              fs_n     = 1'b1;
            end else begin
              to_cnt_n = to_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt  <= '0;
      arm_cnt   <= '0;
      to_cnt    <= '0;
      state     <= S_DISARMED;
      time_work <= '0;
      period    <= '0;
      target    <= MIN_W;
      failsafe  <= 1'b0;
      at_target <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      arm_cnt   <= arm_cnt_n;
      to_cnt    <= to_cnt_n;
      state     <= state_n;
      time_work <= tw_n;
      period    <= PERIOD_W;
      target    <= target_n;
      failsafe  <= fs_n;
      at_target <= (state_n == S_RUN) && (tw_n == target_n);
      cmd_ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_cmd_ramp.sv
// tb_pwm_cmd_ramp: directed scenarios plus random traffic, checked
// against a behavioural model of the command/ramp sequencer.
module tb_pwm_cmd_ramp;

  localparam int TK = 10;
  localparam int ST = 100;
  localparam int MN = 1000;
  localparam int MX = 2000;
  localparam int PR = 20000;
  localparam int AT = 3;
  localparam int TO = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [23:0] cmd_width = '0;
  logic        cmd_ready;
  logic [23:0] time_work;
  logic [23:0] period;
  logic [1:0]  state;
  logic        failsafe;
  logic        at_target;
  logic [52:0] dut_vec;

  int checks = 0;
  int errors = 0;

  int m_state, m_tw, m_target, m_fs, m_at;
  int m_ready, m_period, m_tick, m_arm, m_to;

  pwm_cmd_ramp #(
    .TICK_CYCLES(TK), .STEP(ST), .MIN_WIDTH(MN),
    .MAX_WIDTH(MX), .PERIOD(PR), .ARM_TICKS(AT),
    .TIMEOUT_TICKS(TO)
  ) dut (
    .clk(clk), .reset(reset), .arm(arm),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_width(cmd_width), .time_work(time_work),
    .period(period), .state(state),
    .failsafe(failsafe), .at_target(at_target)
  );

  always #5 clk = ~clk;

  assign dut_vec = {state, time_work, period,
                    failsafe, at_target, cmd_ready};

  // Reference: one update per clock from the sequencing rules.
  always @(posedge clk) begin : model
    bit tk, acc;
    int cl, t, d;
    if (reset) begin
      m_state = 0; m_tw = 0; m_target = MN; m_fs = 0;
      m_at = 0; m_ready = 0; m_period = 0;
      m_tick = 0; m_arm = 0; m_to = 0;
    end else begin
      tk = (m_tick == TK - 1);
      m_tick = tk ? 0 : m_tick + 1;
      acc = cmd_valid && (m_ready == 1);
      cl = int'(cmd_width);
      if (cl < MN) cl = MN;
      if (cl > MX) cl = MX;
      m_ready = 1;
      m_period = PR;
      if (!arm) begin
        m_state = 0; m_tw = 0; m_target = MN; m_fs = 0;
      end else if (m_state == 0) begin
        m_state = 1; m_arm = 0; m_tw = MN; m_target = MN;
      end else if (m_state == 1) begin
        if (tk) begin
          m_arm++;
          if (m_arm == AT) begin
            m_state = 2; m_to = 0;
          end
        end
      end else begin
        t = m_target;
        if (tk) begin
          d = (t > m_tw) ? t - m_tw : m_tw - t;
          if (d > ST) d = ST;
          m_tw = (t > m_tw) ? m_tw + d : m_tw - d;
        end
        if (acc) begin
          m_target = cl; m_to = 0; m_state = 2; m_fs = 0;
        end else if (tk && m_state == 2) begin
          m_to++;
          if (m_to == TO) begin
            m_state = 3; m_target = MN; m_fs = 1;
          end
        end
      end
      m_at = (m_state == 2 && m_tw == m_target) ? 1 : 0;
    end
  end

  function automatic logic [52:0] exp_vec();
    return {2'(m_state), 24'(m_tw), 24'(m_period),
            1'(m_fs), 1'(m_at), 1'(m_ready)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int w);
    cmd_valid = 1'b1;
    cmd_width = 24'(w);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; arm = 1'b0; cmd_valid = 1'b0;
    step(); step();
    checks++;
    if (dut_vec !== 53'd0) begin
      errors++;
      $display("FAIL reset_vals got=%h exp=0", dut_vec);
    end
    reset = 1'b0;
    step();
    checks++;
    if ({state, time_work, period, cmd_ready}
        !== {2'd0, 24'd0, 24'd20000, 1'b1}) begin
      errors++;
      $display("FAIL idle st=%0d tw=%0d per=%0d rdy=%0d exp 0/0/20000/1",
               state, time_work, period, cmd_ready);
    end
    send(1500);
    step();
    checks++;
    if (time_work !== 24'd0 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL disarmed_cmd got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_arming();
    arm = 1'b1;
    step();
    checks++;
    if (state !== 2'd1 || time_work !== 24'd1000) begin
      errors++;
      $display("FAIL arm_entry st=%0d tw=%0d exp 1/1000",
               state, time_work);
    end
    for (int i = 0; i < 100 && state != 2'd2; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL arming cyc=%0d got=%h exp=%h",
                 i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (state !== 2'd2 || time_work !== 24'd1000) begin
      errors++;
      $display("FAIL arm_done st=%0d tw=%0d exp 2/1000",
               state, time_work);
    end
  endtask

  task automatic test_ramp();
    int seq[$];
    int prev;
    bit at_ok;
    at_ok = 1'b0;
    prev = int'(time_work);
    send(1250);
    for (int i = 0; i < 40; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL ramp cyc=%0d got=%h exp=%h",
                 i, dut_vec, exp_vec());
      end
      if (int'(time_work) != prev) begin
        seq.push_back(int'(time_work));
        if (time_work == 24'd1250) at_ok = at_target;
        prev = int'(time_work);
      end
    end
    checks++;
    if (seq.size() != 3 || seq[0] != 1100
        || seq[1] != 1200 || seq[2] != 1250 || !at_ok) begin
      errors++;
      $display("FAIL ramp_seq n=%0d at=%0d exp 1100,1200,1250 at=1",
               seq.size(), at_ok);
    end
  endtask

  task automatic test_clamp();
    int prev, changes, mx;
    send(10);
    for (int i = 0; i < 40; i++) step();
    checks++;
    if (time_work !== 24'd1000 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL clamp_low tw=%0d exp=1000", time_work);
    end
    send(5000);
    prev = int'(time_work);
    changes = 0;
    mx = 0;
    for (int i = 0; i < 130; i++) begin
      cmd_valid = (i % 20 == 19);
      cmd_width = 24'd5000;
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL clamp_hi cyc=%0d got=%h exp=%h",
                 i, dut_vec, exp_vec());
      end
      if (int'(time_work) != prev) changes++;
      if (int'(time_work) > mx) mx = int'(time_work);
      prev = int'(time_work);
    end
    cmd_valid = 1'b0;
    checks++;
    if (changes != 10 || mx != 2000 || time_work !== 24'd2000) begin
      errors++;
      $display("FAIL clamp_ramp steps=%0d max=%0d exp 10/2000",
               changes, mx);
    end
  endtask

  task automatic test_timeout();
    int prev, changes;
    send(1500);
    for (int i = 0; i < 80; i++) begin
      cmd_valid = (i % 20 == 19);
      cmd_width = 24'd1500;
      step();
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 100 && state != 2'd3; i++) begin
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL to_wait cyc=%0d got=%h exp=%h",
                 i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (state !== 2'd3 || failsafe !== 1'b1
        || time_work !== 24'd1500) begin
      errors++;
      $display("FAIL to_fire st=%0d fs=%0d tw=%0d exp 3/1/1500",
               state, failsafe, time_work);
    end
    prev = int'(time_work);
    changes = 0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (int'(time_work) != prev) changes++;
      prev = int'(time_work);
    end
    checks++;
    if (changes != 5 || time_work !== 24'd1000
        || state !== 2'd3) begin
      errors++;
      $display("FAIL fs_ramp steps=%0d tw=%0d st=%0d exp 5/1000/3",
               changes, time_work, state);
    end
    send(1200);
    checks++;
    if (state !== 2'd2 || failsafe !== 1'b0) begin
      errors++;
      $display("FAIL fs_exit st=%0d fs=%0d exp 2/0",
               state, failsafe);
    end
    for (int i = 0; i < 40; i++) step();
    checks++;
    if (time_work !== 24'd1200 || at_target !== 1'b1
        || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL fs_recover tw=%0d at=%0d exp 1200/1",
               time_work, at_target);
    end
  endtask

  task automatic test_arm_drop();
    send(2000);
    for (int i = 0; i < 100 && time_work != 24'd1700; i++) begin
      cmd_valid = (i % 20 == 19);
      cmd_width = 24'd2000;
      step();
    end
    cmd_valid = 1'b0;
    arm = 1'b0;
    step();
    checks++;
    if ({state, time_work, failsafe, at_target}
        !== {2'd0, 24'd0, 1'b0, 1'b0}
        || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL arm_drop st=%0d tw=%0d exp 0/0",
               state, time_work);
    end
  endtask

  task automatic test_reset_mid();
    arm = 1'b1;
    for (int i = 0; i < 100 && state != 2'd2; i++) step();
    send(2000);
    for (int i = 0; i < 25; i++) step();
    reset = 1'b1;
    step();
    checks++;
    if (dut_vec !== 53'd0) begin
      errors++;
      $display("FAIL reset_mid got=%h exp=0", dut_vec);
    end
    reset = 1'b0;
    step();
    checks++;
    if (state !== 2'd1 || time_work !== 24'd1000
        || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset_resume st=%0d tw=%0d exp 1/1000",
               state, time_work);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1200; i++) begin
      arm = ($urandom_range(199) != 0);
      if (i < 600)
        cmd_valid = ($urandom_range(3) == 0);
      else
        cmd_valid = ($urandom_range(99) == 0);
      if ($urandom_range(5) == 0)
        cmd_width = 24'($urandom);
      else
        cmd_width = 24'($urandom_range(3000));
      step();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h",
                 i, dut_vec, exp_vec());
      end
    end
    cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arming();
    test_ramp();
    test_clamp();
    test_timeout();
    test_arm_drop();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
